mod_time_counter: RTL

Parametrised modulo time-unit counter for the digital-clock datapath, generalising the fixed mod-60 seconds/minutes counter. It counts between MIN_VAL and MAX_VAL in either direction, emits a registered carry/borrow pulse for cascading, supports synchronous load and user adjustment without carry, and presents the value both in binary and as two registered BCD digits for the display driver. One instance per clock field: seconds, minutes, hours (0–23 or 1–12), and countdown timer fields.

---
 rtl/time_pkg.sv | 23 ++
 rtl/bin2bcd99.sv | 19 +
 rtl/mod_time_counter.sv | 105 ++++++++++
 3 files changed

// File: rtl/time_pkg.sv
// Shared types, constants and the BCD conversion used by the time-unit counters.
package time_pkg;

  // Two-digit BCD value as presented to the display driver
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // Largest value that still fits into two BCD digits
  localparam int BCD_MAX = 99;

  // Split a binary value 0..99 into tens and ones digits
  function automatic bcd2_t bin_to_bcd2(input logic [6:0] bin);
    bcd2_t      r;
    logic [3:0] t;
    t      = 4'(bin / 7'd10);
    r.tens = t;
    r.ones = 4'(bin - (7'(t) * 7'd10));
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd99.sv
// Combinational binary (0..99) to two-digit BCD converter.
module bin2bcd99
  import time_pkg::*;
(
  input  logic [6:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  bcd2_t digits;

  // Convert via the shared package function so every user sees identical digits
  always_comb begin
    digits = bin_to_bcd2(bin_i);
    tens_o = digits.tens;
    ones_o = digits.ones;
  end

endmodule

// File: rtl/mod_time_counter.sv
// Modulo time-unit counter with carry/borrow cascade, load, adjust and BCD output.
module mod_time_counter
  import time_pkg::*;
#(
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 59,
  parameter int W       = $clog2(MAX_VAL + 1)
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         time_in,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         adj,
  output logic [W-1:0] time_counter,
  output logic [3:0]   bcd_tens,
  output logic [3:0]   bcd_ones,
  output logic         time_out,
  output logic         load_err
);

  // Reject parameter sets that cannot be shown as two BCD digits
  if (!((MIN_VAL >= 0) && (MIN_VAL < MAX_VAL) && (MAX_VAL <= BCD_MAX))) begin : g_range_check
    $error("mod_time_counter: need 0 <= MIN_VAL < MAX_VAL <= 99");
  end
  if (W != $clog2(MAX_VAL + 1)) begin : g_width_check
    $error("mod_time_counter: W must not be overridden");
  end

  localparam logic [W-1:0] MIN_W   = W'(MIN_VAL);
  localparam logic [W-1:0] MAX_W   = W'(MAX_VAL);
  localparam bcd2_t        RST_BCD = bin_to_bcd2(7'(MIN_VAL));

  logic [W-1:0] count_q, count_d;
  logic [3:0]   tens_q, tens_d;
  logic [3:0]   ones_q, ones_d;
  logic         time_out_q, time_out_d;
  logic         load_err_q, load_err_d;
  logic         in_range;

  // Next-state: load beats adj beats time_in; only a time_in wrap carries out
  always_comb begin
    count_d    = count_q;
    time_out_d = 1'b0;
    load_err_d = 1'b0;
    in_range   = (int'(count_q) >= MIN_VAL) && (int'(count_q) <= MAX_VAL);
    if (load) begin
      if ((int'(load_val) >= MIN_VAL) && (int'(load_val) <= MAX_VAL)) begin
        count_d = load_val;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (adj || time_in) begin
      if (!in_range) begin
        count_d = MIN_W;
      end else if (up) begin
        if (count_q == MAX_W) begin
          count_d    = MIN_W;
          time_out_d = !adj;
        end else begin
          count_d = count_q + W'(1);
        end
      end else begin
        if (count_q == MIN_W) begin
          count_d    = MAX_W;
          time_out_d = !adj;
        end else begin
          count_d = count_q - W'(1);
        end
      end
    end
  end

  // Digits come from the next-state value so they register alongside the count
  bin2bcd99 u_bcd (
    .bin_i  (7'(count_d)),
    .tens_o (tens_d),
    .ones_o (ones_d)
  );

  // State and registered pulse outputs
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q    <= MIN_W;
      tens_q     <= RST_BCD.tens;
      ones_q     <= RST_BCD.ones;
      time_out_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      time_out_q <= time_out_d;
      load_err_q <= load_err_d;
    end
  end

  assign time_counter = count_q;
  assign bcd_tens     = tens_q;
  assign bcd_ones     = ones_q;
  assign time_out     = time_out_q;
  assign load_err     = load_err_q;

endmodule
